// File: rtl/serial_nibble_comparator_pkg.sv
// Shared definitions for the serial nibble comparator: nibble width, FSM states,
// and index sizing helper.
package serial_nibble_comparator_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    CMP_IDLE = 2'd0,
    CMP_RUN  = 2'd1,
    CMP_DONE = 2'd2
  } cmp_state_e;

  // Index counter width: $clog2 of the nibble count, but never narrower than 1 bit.
  function automatic int unsigned idx_width(input int unsigned nibbles);
    int unsigned w;
    w = $clog2(nibbles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_nibble_comparator_if.sv
// Start/busy/done handshake plus operand and result-flag signals of the comparator.
interface serial_nibble_comparator_if #(
  parameter int unsigned WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             busy;
  logic             done;
  logic             greater;
  logic             equal;
  logic             less;

  modport master (
    output start, op1, op2,
    input  busy, done, greater, equal, less
  );

  modport slave (
    input  start, op1, op2,
    output busy, done, greater, equal, less
  );

endinterface

// File: rtl/serial_nibble_comparator_cell.sv
// One step of the MSB-first compare cascade: folds a single nibble comparison
// into the running greater/equal/less flags.
module nibble_cascade_cell
  import serial_nibble_comparator_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                is_signed,
  input  logic                prev_g,
  input  logic                prev_e,
  input  logic                prev_l,
  output logic                g,
  output logic                e,
  output logic                l
);

  logic cur_gt;
  logic cur_lt;
  logic cur_eq;

  always_comb begin
    cur_eq = (a == b);
    if (is_signed) begin
      cur_gt = ($signed(a) > $signed(b));
      cur_lt = ($signed(a) < $signed(b));
    end else begin
      cur_gt = (a > b);
      cur_lt = (a < b);
    end
    // A decision made on a more significant nibble masks the opposite outcome.
    g = prev_g | (cur_gt & ~prev_l);
    l = prev_l | (cur_lt & ~prev_g);
    e = prev_e & cur_eq;
  end

endmodule

// File: rtl/serial_nibble_comparator.sv
// Multi-cycle signed comparator: walks the operands one nibble per clock, MSB
// nibble first, and stops as soon as the ordering is decided.
module serial_nibble_comparator
  import serial_nibble_comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic                     clk,
  input logic                     rst,
  serial_nibble_comparator_if.slave bus
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NIBBLES - 1);

  cmp_state_e       state_q, state_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             g_q, g_d;
  logic             e_q, e_d;
  logic             l_q, l_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             greater_q, greater_d;
  logic             equal_q, equal_d;
  logic             less_q, less_d;

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic                is_sign_nib;
  logic                cell_g;
  logic                cell_e;
  logic                cell_l;

  always_comb begin
    a_nib       = op1_q[NIBBLE_W*idx_q +: NIBBLE_W];
    b_nib       = op2_q[NIBBLE_W*idx_q +: NIBBLE_W];
    is_sign_nib = (idx_q == IDX_MAX);
  end

  nibble_cascade_cell u_cell (
    .a         (a_nib),
    .b         (b_nib),
    .is_signed (is_sign_nib),
    .prev_g    (g_q),
    .prev_e    (e_q),
    .prev_l    (l_q),
    .g         (cell_g),
    .e         (cell_e),
    .l         (cell_l)
  );

  always_comb begin
    state_d   = state_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    idx_d     = idx_q;
    g_d       = g_q;
    e_d       = e_q;
    l_d       = l_q;
    greater_d = greater_q;
    equal_d   = equal_q;
    less_d    = less_q;

    unique case (state_q)
      CMP_IDLE, CMP_DONE: begin
        if (bus.start) begin
          op1_d   = bus.op1;
          op2_d   = bus.op2;
          idx_d   = IDX_MAX;
          g_d     = 1'b0;
          e_d     = 1'b1;
          l_d     = 1'b0;
          state_d = CMP_RUN;
        end else begin
          state_d = CMP_IDLE;
        end
      end
      CMP_RUN: begin
        g_d = cell_g;
        e_d = cell_e;
        l_d = cell_l;
        if ((idx_q == '0) || cell_g || cell_l) begin
          state_d   = CMP_DONE;
          greater_d = cell_g;
          equal_d   = cell_e;
          less_d    = cell_l;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = CMP_IDLE;
    endcase

    busy_d = (state_d == CMP_RUN);
    done_d = (state_d == CMP_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CMP_IDLE;
      op1_q     <= '0;
      op2_q     <= '0;
      idx_q     <= '0;
      g_q       <= 1'b0;
      e_q       <= 1'b0;
      l_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      greater_q <= 1'b0;
      equal_q   <= 1'b0;
      less_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      idx_q     <= idx_d;
      g_q       <= g_d;
      e_q       <= e_d;
      l_q       <= l_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      greater_q <= greater_d;
      equal_q   <= equal_d;
      less_q    <= less_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.greater = greater_q;
  assign bus.equal   = equal_q;
  assign bus.less    = less_q;

endmodule

// File: tb/tb_serial_nibble_comparator.sv
// Directed bench for serial_nibble_comparator at WIDTH=16: latency, flags,
// handshake corner cases and mid-operation reset.
module tb_serial_nibble_comparator;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  serial_nibble_comparator_if #(.WIDTH(16)) bus ();

  serial_nibble_comparator #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Assert start with operands so it is sampled at the next edge (E0); returns #1 after E0.
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op1   = a;
    bus.op2   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count edges after E0 until done is seen; k0 edges already elapsed.
  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (!bus.done && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic check_result(input string tag, input int k, input int exp_k,
                              input logic g, input logic e, input logic l);
    check({tag, "_latency"}, 32'(k), 32'(exp_k));
    check({tag, "_done"},    32'(bus.done), 32'd1);
    check({tag, "_busy"},    32'(bus.busy), 32'd0);
    check({tag, "_gel"},     {29'd0, bus.greater, bus.equal, bus.less}, {29'd0, g, e, l});
  endtask

  task automatic run_cmp(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input int exp_k, input logic g, input logic e, input logic l);
    int k;
    launch(a, b);
    check({tag, "_busy_e0"}, 32'(bus.busy), 32'd1);
    wait_done(0, k);
    check_result(tag, k, exp_k, g, e, l);
  endtask

  initial begin
    int k;
    errors    = 0;
    checks    = 0;
    bus.start = 1'b0;
    bus.op1   = '0;
    bus.op2   = '0;
    rst       = 1'b1;
    #1;
    check("reset_outs", {27'd0, bus.busy, bus.done, bus.greater, bus.equal, bus.less}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_outs", {27'd0, bus.busy, bus.done, bus.greater, bus.equal, bus.less}, 32'd0);

    run_cmp("eq_1234",    16'h1234, 16'h1234, 4, 1'b0, 1'b1, 1'b0);
    run_cmp("sign_8000",  16'h8000, 16'h7FFF, 1, 1'b0, 1'b0, 1'b1);
    run_cmp("low_0080",   16'h0080, 16'h0070, 3, 1'b1, 1'b0, 1'b0);
    run_cmp("neg_FFFF",   16'hFFFF, 16'hFFFE, 4, 1'b1, 1'b0, 1'b0);
    run_cmp("sign_0000",  16'h0000, 16'h8000, 1, 1'b1, 1'b0, 1'b0);
    run_cmp("mid_12F0",   16'h12F0, 16'h1300, 2, 1'b0, 1'b0, 1'b1);

    // Done lasts one cycle, then IDLE with flags held.
    @(posedge clk);
    #1;
    check("done_pulse_end", {30'd0, bus.busy, bus.done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("flags_hold", {29'd0, bus.greater, bus.equal, bus.less}, 32'b001);

    // New start does not clear held flags while the comparison runs.
    launch(16'h1234, 16'h1234);
    check("flags_kept_on_start", {29'd0, bus.greater, bus.equal, bus.less}, 32'b001);
    // Start pulsed with other operands while busy must be ignored.
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op1   = 16'h8000;
    bus.op2   = 16'h7FFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op1   = 16'h0001;
    bus.op2   = 16'h0002;
    check("busy_ignore_busy", 32'(bus.busy), 32'd1);
    wait_done(2, k);
    check_result("busy_ignore", k, 4, 1'b0, 1'b1, 1'b0);

    // Start held during the DONE cycle launches the next comparison immediately.
    bus.start = 1'b1;
    bus.op1   = 16'hFFFF;
    bus.op2   = 16'hFFFE;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("b2b_busy", {30'd0, bus.busy, bus.done}, 32'b10);
    wait_done(0, k);
    check_result("b2b", k, 4, 1'b1, 1'b0, 1'b0);

    // Reset after edge 2 of an equal compare: outputs clear at once, no done.
    launch(16'h1234, 16'h1234);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_outs", {27'd0, bus.busy, bus.done, bus.greater, bus.equal, bus.less}, 32'd0);
    repeat (4) begin
      @(posedge clk);
      #1;
      check("rst_hold_no_done", 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_after_idle", {27'd0, bus.busy, bus.done, bus.greater, bus.equal, bus.less}, 32'd0);
    run_cmp("post_rst", 16'h0080, 16'h0070, 3, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
